// File: rtl/date_setter_pkg.sv
// Shared calendar widths, editor FSM states and calendar-rule helpers.
// The date counter imports the same functions so both blocks agree on month lengths.
package date_pkg;

  localparam int YEAR_W  = 14;
  localparam int MONTH_W = 4;
  localparam int DAY_W   = 5;
  localparam int DATE_W  = 23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ED_YEAR,
    ST_ED_MONTH,
    ST_ED_DAY,
    ST_COMMIT
  } state_e;

  function automatic logic is_leap(input logic [YEAR_W-1:0] year);
    logic leap;
    leap = ((year % 14'd4 == 14'd0) && (year % 14'd100 != 14'd0)) ||
           (year % 14'd400 == 14'd0);
    return leap;
  endfunction

  function automatic logic [DAY_W-1:0] days_in_month(input logic [YEAR_W-1:0]  year,
                                                     input logic [MONTH_W-1:0] month);
    logic [DAY_W-1:0] dim;
    case (month)
      4'd2:                      dim = is_leap(year) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   dim = 5'd30;
      default:                   dim = 5'd31;
    endcase
    return dim;
  endfunction

endpackage

// File: rtl/date_setter_if.sv
// Key pulses, live date and load port between the debouncer, the editor and the date counter.
interface date_setter_if;
  import date_pkg::*;

  logic              key_mode;
  logic              key_next;
  logic              key_up;
  logic              key_down;
  logic [DATE_W-1:0] cur_date;
  logic              set_date;
  logic [DATE_W-1:0] bin_date;
  logic              editing;
  logic [1:0]        field;

  modport master (
    output key_mode, key_next, key_up, key_down, cur_date,
    input  set_date, bin_date, editing, field
  );

  modport slave (
    input  key_mode, key_next, key_up, key_down, cur_date,
    output set_date, bin_date, editing, field
  );
endinterface

// File: rtl/date_setter.sv
// Date editor: walks a cursor over year/month/day, keeps every intermediate date
// legal, and strobes set_date with the edited word on commit.
//
// state       | meaning
// ST_IDLE     | not editing, bin_date holds last edit value
// ST_ED_YEAR  | cursor on year
// ST_ED_MONTH | cursor on month
// ST_ED_DAY   | cursor on day
// ST_COMMIT   | one-cycle set_date strobe
module date_setter
  import date_pkg::*;
#(
  parameter int          YEAR_MAX    = 9999,
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
  input  logic         clk,
  input  logic         rst,
  date_setter_if.slave bus
);

  localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);

  state_e             state_q, state_d;
  logic [YEAR_W-1:0]  year_q, year_d;
  logic [MONTH_W-1:0] month_q, month_d;
  logic [DAY_W-1:0]   day_q, day_d;
  logic [31:0]        cnt_q, cnt_d;

  logic [YEAR_W-1:0]  cur_y, san_y, new_y;
  logic [MONTH_W-1:0] cur_m, san_m, new_m;
  logic [DAY_W-1:0]   cur_d, san_d, new_d, dim_san, dim_new;
  logic               in_edit, any_key;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      year_q  <= 14'd1;
      month_q <= 4'd1;
      day_q   <= 5'd1;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    new_y   = year_q;
    new_m   = month_q;
    new_d   = day_q;
    dim_new = days_in_month(year_q, month_q);

    in_edit = (state_q == ST_ED_YEAR) || (state_q == ST_ED_MONTH) || (state_q == ST_ED_DAY);
    any_key = bus.key_mode || bus.key_next || bus.key_up || bus.key_down;

    // Live date may be garbage (e.g. after power-up), so force it legal on capture.
    cur_y   = bus.cur_date[DATE_W-1 -: YEAR_W];
    cur_m   = bus.cur_date[DAY_W +: MONTH_W];
    cur_d   = bus.cur_date[DAY_W-1:0];
    san_y   = (cur_y == 14'd0) ? 14'd1 : ((cur_y > YMAX) ? YMAX : cur_y);
    san_m   = ((cur_m == 4'd0) || (cur_m > 4'd12)) ? 4'd1 : cur_m;
    dim_san = days_in_month(san_y, san_m);
    san_d   = (cur_d == 5'd0) ? 5'd1 : ((cur_d > dim_san) ? dim_san : cur_d);

    case (state_q)
      ST_IDLE: begin
        if (bus.key_mode) begin
          year_d  = san_y;
          month_d = san_m;
          day_d   = san_d;
          state_d = ST_ED_YEAR;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default: begin
        if (bus.key_mode) begin
          state_d = ST_COMMIT;
        end else if (bus.key_next) begin
          case (state_q)
            ST_ED_YEAR:  state_d = ST_ED_MONTH;
            ST_ED_MONTH: state_d = ST_ED_DAY;
            default:     state_d = ST_ED_YEAR;
          endcase
        end else if (bus.key_up || bus.key_down) begin
          // Wrap is decided before the add/sub so nothing spills past the field width.
          case (state_q)
            ST_ED_YEAR:
              if (bus.key_up) new_y = (year_q >= YMAX) ? 14'd1 : year_q + 14'd1;
              else            new_y = (year_q <= 14'd1) ? YMAX : year_q - 14'd1;
            ST_ED_MONTH:
              if (bus.key_up) new_m = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
              else            new_m = (month_q <= 4'd1) ? 4'd12 : month_q - 4'd1;
            default:
              if (bus.key_up) new_d = (day_q >= dim_new) ? 5'd1 : day_q + 5'd1;
              else            new_d = (day_q <= 5'd1) ? dim_new : day_q - 5'd1;
          endcase
          dim_new = days_in_month(new_y, new_m);
          year_d  = new_y;
          month_d = new_m;
          day_d   = (new_d > dim_new) ? dim_new : new_d;
        end else if (cnt_q >= TIMEOUT_CYC - 32'd1) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    cnt_d = (!in_edit || any_key || (state_d != state_q)) ? 32'd0 : cnt_q + 32'd1;
  end

  assign bus.set_date = (state_q == ST_COMMIT);
  assign bus.bin_date = {year_q, month_q, day_q};
  assign bus.editing  = (state_q == ST_ED_YEAR) || (state_q == ST_ED_MONTH) ||
                        (state_q == ST_ED_DAY);
  assign bus.field    = (state_q == ST_ED_YEAR)  ? 2'd0 :
                        (state_q == ST_ED_MONTH) ? 2'd1 :
                        (state_q == ST_ED_DAY)   ? 2'd2 : 2'd3;

endmodule

// File: doc/date_setter.md
# date_setter

User-facing editor that writes the 23-bit `{year, month, day}` load word into the calendar counter. It takes debounced single-cycle key pulses, walks an edit cursor over the year, month and day fields, and keeps every intermediate date legal, including leap years and month lengths. On confirmation it emits a one-cycle `set_date` strobe with `bin_date`. It sits between the key debouncer and the date counter's load port.

## Interface
- `YEAR_MAX`, 9999: upper year limit; year range is 1..YEAR_MAX.
- `TIMEOUT_CYC`, 32'd50_000_000: idle cycles in an edit state before the edit is abandoned.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `key_mode` in 1: enter edit / commit, one-cycle pulse.
- `key_next` in 1: advance edit cursor, one-cycle pulse.
- `key_up` in 1: increment selected field.
- `key_down` in 1: decrement selected field.
- `cur_date` in 23: live date `{year[13:0], month[3:0], day[4:0]}` from the date counter.
- `set_date` out 1: load strobe to the date counter.
- `bin_date` out 23: edit value `{year, month, day}`; the date counter loads it when `set_date` is high.
- `editing` out 1: high in any edit state, for display blink.
- `field` out 2: cursor position. 0 = year, 1 = month, 2 = day, 3 = none/idle.

## Operation
- **States:** IDLE, ED_YEAR, ED_MONTH, ED_DAY, COMMIT.
- **Leaving IDLE:** `key_mode` captures `cur_date` into the edit registers with sanitising, then moves to ED_YEAR.
  - Year 0 → 1; year > YEAR_MAX → YEAR_MAX.
  - Month 0 or > 12 → 1.
  - Day 0 → 1; day > dim(year, month) → dim.
- **Cursor:** `key_next` steps ED_YEAR → ED_MONTH → ED_DAY → ED_YEAR.
- **Field edits:** `key_up` / `key_down` change the selected field with wrap.
  - Year: YEAR_MAX+1 → 1, 0 → YEAR_MAX.
  - Month: 13 → 1, 0 → 12.
  - Day: dim+1 → 1, 0 → dim.
- **Day clamp:** any year or month change also clamps day in the same update, as new day = min(day, dim(new year, new month)). Example: Mar 31, month down → Feb 28 or Feb 29.
- **Commit:** `key_mode` in an edit state → COMMIT. COMMIT asserts `set_date` for one cycle, then goes to IDLE unconditionally.
- **Key priority:** at most one key acts per cycle, in the order `key_mode` > `key_next` > `key_up` > `key_down`. Lower-priority keys in the same cycle are dropped. Keys in COMMIT are ignored.
- **Timeout:** the counter clears on any key pulse and on state entry. Reaching TIMEOUT_CYC in an edit state → IDLE with no `set_date`. The edit registers keep their value.
- **Leap rule:** leap = (y%4==0 && y%100!=0) || y%400==0. dim: Feb = 28+leap; Apr, Jun, Sep, Nov = 30; all others 31.
- **Idle:** in IDLE, `bin_date` holds the last edit value. `set_date` is never high outside COMMIT.

## Timing
- **Reset values:** state IDLE, `set_date` 0, `editing` 0, `field` 3, `bin_date` = {14'd1, 4'd1, 5'd1}, timeout counter 0.
- **Registered outputs:** `editing` and `field` follow the state register. They change the cycle after the key.
- **Field latency:** a key at edge N updates the field at edge N+1, and `bin_date` shows it after that edge.
- **Commit latency:** `key_mode` in edit at edge N gives `set_date` = 1 for the cycle after edge N+1 (COMMIT), then 0. `bin_date` is stable for the whole COMMIT cycle.
- **Reset mid-edit:** `rst` low at any time forces reset values immediately. No partial `set_date` is produced.
- **Widths:** year is 14 bits unsigned. Wrap comparisons are done before the add/sub, so no overflow leaks into the month or day bits.

## Structure
- Package `date_pkg`:
  - Widths: YEAR_W = 14, MONTH_W = 4, DAY_W = 5, DATE_W = 23.
  - State enum for this FSM.
  - Functions `is_leap(year)` and `days_in_month(year, month)`. The date counter uses the same functions so both blocks agree on calendar rules.
- No sub-module. The timeout counter and the field update mux stay inline, at roughly 200 lines.

## Test plan
- **Enter and commit:** `cur_date` = 2024-02-15. Pulse `key_mode`, then `key_mode` → `set_date` for exactly one cycle with `bin_date` = {2024, 2, 15}. Final state IDLE, `field` = 3.
- **Leap clamp:** from 2024-02-29, on ED_YEAR pulse `key_up` → 2025-02-28. Then `key_down` → 2024-02-28; the day does not restore to 29.
- **Wraps:**
  - Year 9999 `key_up` → 1; year 1 `key_down` → 9999.
  - Month 12 `key_up` → 1.
  - Day 1 in April, `key_down` → 30.
- **Sanitise:** `cur_date` = {0, 0, 0}, `key_mode` → `bin_date` = {1, 1, 1}. `cur_date` = 2023-02-30 → 2023-02-28.
- **Priority:** `key_up` and `key_down` together → only +1. `key_mode` and `key_up` together in ED_DAY → commit without incrementing.
- **Timeout and reset:** TIMEOUT_CYC = 10, no key for 10 cycles → IDLE with `set_date` never asserted. `rst` low during ED_MONTH → all outputs at reset values the same cycle.
